// File: rtl/issue_queue_id2p.sv
// issue_queue_id2p: circular FIFO between ID1 and ID2 of the dual-issue front end.
// Up to two decoded instructions are accepted per cycle (lane0 oldest) and the
// two oldest entries are presented to ID2, which consumes 0, 1 or 2 per cycle.
// Handshake: an ID1 lane is taken when its valid is high and enq_ready is high
// (lane1 only together with lane0); ID2 consumes min(issue_cnt, count, 2)
// entries per cycle unless stall is high.
module issue_queue_id2p #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 180,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   exception_flush,
    input  logic                   stall,
    input  logic [1:0]             enq_valid,
    input  logic [2*PAYLOAD_W-1:0] enq_data,
    output logic                   enq_ready,
    output logic [1:0]             deq_valid,
    output logic [2*PAYLOAD_W-1:0] deq_data,
    input  logic [1:0]             issue_cnt,
    output logic [CNT_W-1:0]       count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_nx, wr_ptr_nx;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 acc0, acc1, clear;
    logic [1:0]           n_enq, n_deq, issue_lim;

    // Ready looks only at registered occupancy; same-cycle dequeue is not credited.
    assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign acc0      = enq_valid[0] & enq_ready;
    assign acc1      = enq_valid[1] & enq_valid[0] & enq_ready;
    assign n_enq     = acc1 ? 2'd2 : (acc0 ? 2'd1 : 2'd0);

    // Exception flush wins unconditionally; mispredict flush waits for stall to drop.
    assign clear     = exception_flush | (flush & ~stall);

    assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);

    // Number of entries ID2 actually removes: clamp issue_cnt to 2 and to occupancy.
    always_comb begin
        issue_lim = issue_cnt[1] ? 2'd2 : issue_cnt;
        n_deq     = 2'd0;
        if (!stall) begin
            if (count_q >= CNT_W'(2)) begin
                n_deq = issue_lim;
            end else if (count_q == CNT_W'(1)) begin
                n_deq = (issue_lim != 2'd0) ? 2'd1 : 2'd0;
            end
        end
    end

    // Next pointer/occupancy state, with flush clearing everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
        count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents need no reset since valid is tracked by count.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (acc0) mem_q[wr_ptr_q]  <= enq_data[PAYLOAD_W-1:0];
            if (acc1) mem_q[wr_ptr_nx] <= enq_data[2*PAYLOAD_W-1:PAYLOAD_W];
        end
    end

    // Head and head+1 to ID2, zeroed when not valid.
    always_comb begin
        deq_valid[0] = (count_q != '0);
        deq_valid[1] = (count_q >= CNT_W'(2));
        deq_data     = '0;
        if (deq_valid[0]) deq_data[PAYLOAD_W-1:0]           = mem_q[rd_ptr_q];
        if (deq_valid[1]) deq_data[2*PAYLOAD_W-1:PAYLOAD_W] = mem_q[rd_ptr_nx];
    end

    assign count = count_q;

endmodule

// File: doc/issue_queue_id2p.md
Name: issue_queue_id2p

Overview:
- Parametrised successor to the single-entry ID1->ID2 pipeline register.
- Circular FIFO between ID1 and ID2 of the dual-issue front end. Accepts up to 2 decoded instructions per cycle from ID1 and presents the 2 oldest to the ID2 issue logic.
- Decouples decode from issue stalls and supports partial (single) issue.
- Honours branch-mispredict flush and exception flush with distinct priorities.

Parameters:
- DEPTH, 8, number of entries; power of two, >=4.
- PAYLOAD_W, 180, bits per entry (op_codes, func_codes, pc, inst, rs/rt/rd/sa, w_reg_ena/dst, imme, j_imme, in_delay_slot, concatenated by ID1).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  mispredict flush; honoured only when stall=0.
- exception_flush  in  1  exception flush; unconditional, highest priority.
- stall  in  1  ID2 stall; blocks dequeue.
- enq_valid  in  2  per-lane valid from ID1; lane0 oldest.
- enq_data  in  2*PAYLOAD_W  lane0 in [PAYLOAD_W-1:0].
- enq_ready  out  1  queue can accept 2 entries this cycle.
- deq_valid  out  2  head/head+1 valid to ID2.
- deq_data  out  2*PAYLOAD_W  head in lane0.
- issue_cnt  in  2  entries ID2 consumes this cycle (0,1,2).
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, enq_ready=1, deq_valid=0, deq_data=0. Storage contents are don't-care. Reset deasserting mid-stream needs no special handling.
- enq_ready = (DEPTH - count) >= 2. It depends on registered count only and does not credit same-cycle dequeue.
- Enqueue: n_enq = number of accepted lanes.
  - lane0 accepted if enq_valid[0] & enq_ready.
  - lane1 accepted if enq_valid[1] & enq_valid[0] & enq_ready.
  - enq_valid=2'b10 is a protocol error; lane1 is ignored and nothing is written.
  - Accepted entries are written at wr_ptr and wr_ptr+1 (mod DEPTH). wr_ptr advances by n_enq.
- Dequeue outputs are combinational from registered state:
  - deq_valid[0] = count>=1; deq_valid[1] = count>=2.
  - deq_data lanes show storage[rd_ptr] and storage[rd_ptr+1]. A lane's data is forced to 0 when its valid is 0.
- Dequeue: n_deq = stall ? 0 : min(issue_cnt, count, 2). issue_cnt=3 is treated as 2. rd_ptr advances by n_deq.
- Latency: an entry written at edge N is visible on deq_* after edge N (cycle N+1). There is no bypass; an empty queue outputs invalid in the same cycle ID1 presents data.
- count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue are both applied.
- Pointers are log2(DEPTH) bits and wrap naturally. Full is count==DEPTH; empty is count==0.
- Flush priority (synchronous, highest first):
  1. exception_flush=1: rd_ptr=wr_ptr=0, count=0. Same-cycle enqueue and dequeue are discarded, regardless of stall.
  2. flush=1 & stall=0: same clear; same-cycle enqueue is discarded.
  3. flush=1 & stall=1: flush is ignored this cycle. ID1/control must hold flush until stall drops. No state change beyond normal enqueue; dequeue is blocked by stall.
- stall=1 without flush: enqueue continues while enq_ready=1; deq outputs hold.
- Delay-slot pairing is not enforced here; ID2 issue logic decides issue_cnt.

Test Plan:
- Reset, then enq 2'b11 with payloads A,B, issue_cnt=0 -> next cycle deq_valid=2'b11, lane0=A, lane1=B, count=2.
- Fill to DEPTH-1=7 with stall=1 -> enq_ready=0 at count 7. Then enq_valid=2'b11 -> no write, count stays 7.
- count=3 (A,B,C), issue_cnt=1, enq 2'b01 D -> next count=3, head=B, head+1=C. Then issue_cnt=2 -> head=D, count=1. Run enough traffic to wrap rd_ptr and wr_ptr through 7->0 with ordering preserved.
- count=4, flush=1 & stall=1 -> count stays 4. Next cycle flush=1, stall=0, enq 2'b11 -> count=0, deq_valid=0, deq_data=0.
- count=5, exception_flush=1 with stall=1, enq 2'b11, issue_cnt=2 -> count=0. Separately, assert rst=0 mid-operation asynchronously (between edges) -> count=0 and deq_valid=0 immediately.
- enq_valid=2'b10 on empty queue -> count stays 0. issue_cnt=2 with count=1 -> count=0, no underflow.
